// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and the CDB entry record used by the arbiter and its consumers
// (ROB, RS, LSB).
package cdb_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int ROB_ID_W = 5;

  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0]     result;
    logic [ROB_ID_W-1:0] rob_id;
    logic                jump;
    logic [XLEN-1:0]     jump_pc;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Small synchronous per-source FIFO with flush. The head is read straight from
// the storage array so a grant can act on it in the same cycle it becomes valid.
module cdb_src_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              full;
  logic              do_push;
  logic              do_pop;

  // Eligibility uses the start-of-cycle count: a pop never frees a slot for
  // a push in the same cycle.
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that serialises ALU and LSB results onto one registered
// common data bus. FIFO_DEPTH must be a power of two and at least 2.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int XLEN       = cdb_arbiter_pkg::XLEN,
  parameter int ROB_ID_W   = cdb_arbiter_pkg::ROB_ID_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                wrong_commit,
  input  logic                alu_valid,
  input  logic [XLEN-1:0]     alu_result,
  input  logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic                alu_jump,
  input  logic [XLEN-1:0]     alu_jump_pc,
  output logic                alu_almost_full,
  input  logic                lsb_valid,
  input  logic [XLEN-1:0]     lsb_result,
  input  logic [ROB_ID_W-1:0] lsb_rob_id,
  output logic                lsb_ready,
  output logic                cdb_valid,
  output logic [XLEN-1:0]     cdb_result,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic                cdb_jump,
  output logic [XLEN-1:0]     cdb_jump_pc,
  output logic                cdb_src,
  output logic                overflow_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0]     result;
    logic [ROB_ID_W-1:0] rob_id;
    logic                jump;
    logic [XLEN-1:0]     jump_pc;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t             alu_in;
  entry_t             lsb_in;
  entry_t             alu_head;
  entry_t             lsb_head;
  entry_t             grant_head;
  logic [CNT_W-1:0]   alu_count;
  logic [CNT_W-1:0]   lsb_count;
  logic               alu_empty;
  logic               lsb_empty;
  logic               alu_full;
  logic               accept_in;
  logic               flush;
  logic               alu_push;
  logic               lsb_push;
  logic               alu_pop;
  logic               lsb_pop;
  logic               alu_overflow;
  logic               grant_valid;
  logic               grant_src;

  logic               rr_ptr_reg;
  logic               cdb_valid_reg;
  logic [XLEN-1:0]    cdb_result_reg;
  logic [ROB_ID_W-1:0] cdb_rob_id_reg;
  logic               cdb_jump_reg;
  logic [XLEN-1:0]    cdb_jump_pc_reg;
  logic               cdb_src_reg;
  logic               overflow_err_reg;

  assign alu_in = '{result: alu_result, rob_id: alu_rob_id, jump: alu_jump, jump_pc: alu_jump_pc};
  assign lsb_in = '{result: lsb_result, rob_id: lsb_rob_id, jump: 1'b0, jump_pc: '0};

  // A frozen cycle (rdy low) must not move any state; a flush swallows pushes.
  assign accept_in    = rdy && !wrong_commit;
  assign flush        = rdy && wrong_commit;
  assign alu_full     = (alu_count == CNT_W'(FIFO_DEPTH));
  assign alu_push     = accept_in && alu_valid;
  assign lsb_push     = accept_in && lsb_valid;
  assign alu_overflow = accept_in && alu_valid && alu_full;

  cdb_src_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (alu_push),
    .push_data (alu_in),
    .pop       (alu_pop),
    .head      (alu_head),
    .count     (alu_count),
    .empty     (alu_empty)
  );

  cdb_src_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_lsb_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (lsb_push),
    .push_data (lsb_in),
    .pop       (lsb_pop),
    .head      (lsb_head),
    .count     (lsb_count),
    .empty     (lsb_empty)
  );

  always_comb begin
    grant_valid = 1'b0;
    grant_src   = CDB_SRC_ALU;
    if (!alu_empty && !lsb_empty) begin
      grant_valid = 1'b1;
      grant_src   = rr_ptr_reg;
    end else if (!alu_empty) begin
      grant_valid = 1'b1;
      grant_src   = CDB_SRC_ALU;
    end else if (!lsb_empty) begin
      grant_valid = 1'b1;
      grant_src   = CDB_SRC_LSB;
    end
  end

  assign grant_head = (grant_src == CDB_SRC_LSB) ? lsb_head : alu_head;
  assign alu_pop    = accept_in && grant_valid && (grant_src == CDB_SRC_ALU);
  assign lsb_pop    = accept_in && grant_valid && (grant_src == CDB_SRC_LSB);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_reg       <= CDB_SRC_ALU;
      cdb_valid_reg    <= 1'b0;
      cdb_result_reg   <= '0;
      cdb_rob_id_reg   <= '0;
      cdb_jump_reg     <= 1'b0;
      cdb_jump_pc_reg  <= '0;
      cdb_src_reg      <= CDB_SRC_ALU;
      overflow_err_reg <= 1'b0;
    end else if (rdy) begin
      if (wrong_commit) begin
        cdb_valid_reg <= 1'b0;
        rr_ptr_reg    <= CDB_SRC_ALU;
      end else if (grant_valid) begin
        cdb_valid_reg   <= 1'b1;
        cdb_src_reg     <= grant_src;
        cdb_result_reg  <= grant_head.result;
        cdb_rob_id_reg  <= grant_head.rob_id;
        // Load results never carry branch information.
        cdb_jump_reg    <= grant_head.jump & (grant_src == CDB_SRC_ALU);
        cdb_jump_pc_reg <= (grant_src == CDB_SRC_ALU) ? grant_head.jump_pc : '0;
        rr_ptr_reg      <= ~grant_src;
      end else begin
        cdb_valid_reg <= 1'b0;
      end
      if (alu_overflow) overflow_err_reg <= 1'b1;
    end
  end

  // Flags come from registered counts so the RS/LSB see a stable value all cycle.
  assign alu_almost_full = (alu_count >= CNT_W'(FIFO_DEPTH - 1));
  assign lsb_ready       = (lsb_count < CNT_W'(FIFO_DEPTH));

  assign cdb_valid    = cdb_valid_reg;
  assign cdb_result   = cdb_result_reg;
  assign cdb_rob_id   = cdb_rob_id_reg;
  assign cdb_jump     = cdb_jump_reg;
  assign cdb_jump_pc  = cdb_jump_pc_reg;
  assign cdb_src      = cdb_src_reg;
  assign overflow_err = overflow_err_reg;

endmodule
